// File: rtl/keypad_entry_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_buffer_if
// Description : Bundles the key/command inputs and the result/display outputs
//               of keypad_entry_buffer. The master drives keys and commands.
//               The slave (the entry buffer) returns status, result and
//               display data.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_entry_buffer_if #(
  parameter int MAX_DIGITS = 4,
  parameter int VALUE_W    = 16
);
  localparam int C_CNT_W = $clog2(MAX_DIGITS + 1);

  logic                    start;
  logic                    mask_en;
  logic                    key_valid;
  logic [7:0]              key_code;
  logic                    busy;
  logic                    done;
  logic                    cancel;
  logic                    timeout;
  logic                    ovf;
  logic                    key_reject;
  logic [VALUE_W-1:0]      value;
  logic [C_CNT_W-1:0]      digit_count;
  logic [4*MAX_DIGITS-1:0] disp_digits;
  logic [MAX_DIGITS-1:0]   disp_blank;

  modport master (
    output start, mask_en, key_valid, key_code,
    input  busy, done, cancel, timeout, ovf, key_reject,
    input  value, digit_count, disp_digits, disp_blank
  );

  modport slave (
    input  start, mask_en, key_valid, key_code,
    output busy, done, cancel, timeout, ovf, key_reject,
    output value, digit_count, disp_digits, disp_blank
  );
endinterface
`default_nettype wire

// File: rtl/keypad_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_buffer
// Description : Multi-digit numeric entry collector. It buffers ASCII digits
//               and supports backspace, ESC cancel and an inactivity timeout.
//               On ENTER it converts the buffered decimal digits to binary,
//               one digit per cycle, and pulses done with the result.
//               The display outputs can mask digits for PIN entry.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_buffer #(
  parameter int MAX_DIGITS     = 4,
  parameter int MIN_DIGITS     = 1,
  parameter int VALUE_W        = 16,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  keypad_entry_buffer_if.slave  kp
);

  localparam int C_CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int C_BUF_W = 4 * MAX_DIGITS;
  localparam int C_ACC_W = VALUE_W + 4;
  localparam int C_TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [C_TO_W-1:0] C_TO_LAST =
    C_TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [7:0] C_KEY_BS    = 8'h08;
  localparam logic [7:0] C_KEY_ENTER = 8'h0D;
  localparam logic [7:0] C_KEY_ESC   = 8'h1B;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CONVERT = 2'd2
  } state_t;

  state_t               r_state,   w_state_nxt;
  logic [C_BUF_W-1:0]   r_buf,     w_buf_nxt;
  logic [C_CNT_W-1:0]   r_count,   w_count_nxt;
  logic                 r_mask,    w_mask_nxt;
  logic [C_TO_W-1:0]    r_idle,    w_idle_nxt;
  logic [C_ACC_W-1:0]   r_acc,     w_acc_nxt;
  logic [C_CNT_W-1:0]   r_idx,     w_idx_nxt;
  logic                 r_ovf_acc, w_ovf_acc_nxt;
  logic [VALUE_W-1:0]   r_value,   w_value_nxt;
  logic                 r_ovf,     w_ovf_nxt;
  logic                 r_done,    w_done_nxt;
  logic                 r_cancel,  w_cancel_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic                 r_reject,  w_reject_nxt;
  logic                 r_disp_en;

  logic                 w_is_digit;
  logic [3:0]           w_conv_digit;
  logic [C_ACC_W-1:0]   w_acc_step;
  logic [C_BUF_W-1:0]   w_disp;
  logic [MAX_DIGITS-1:0] w_blank;

  assign w_is_digit = (kp.key_code[7:4] == 4'h3) && (kp.key_code[3:0] <= 4'd9);
  assign w_acc_step = (r_acc * C_ACC_W'(10)) + C_ACC_W'(w_conv_digit);

  // Select the digit being converted; r_idx counts down so the oldest digit goes first
  always_comb begin
    w_conv_digit = 4'h0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (r_idx == C_CNT_W'(i + 1)) begin
        w_conv_digit = r_buf[4*i +: 4];
      end
    end
  end

  // Next-state and datapath decisions for the entry/convert sequence
  always_comb begin
    w_state_nxt   = r_state;
    w_buf_nxt     = r_buf;
    w_count_nxt   = r_count;
    w_mask_nxt    = r_mask;
    w_idle_nxt    = r_idle;
    w_acc_nxt     = r_acc;
    w_idx_nxt     = r_idx;
    w_ovf_acc_nxt = r_ovf_acc;
    w_value_nxt   = r_value;
    w_ovf_nxt     = r_ovf;
    w_done_nxt    = 1'b0;
    w_cancel_nxt  = 1'b0;
    w_timeout_nxt = 1'b0;
    w_reject_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A key in the same cycle as start is dropped without a reject pulse
        if (kp.start) begin
          w_state_nxt = S_COLLECT;
          w_buf_nxt   = '0;
          w_count_nxt = '0;
          w_mask_nxt  = kp.mask_en;
          w_idle_nxt  = '0;
          w_value_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      S_COLLECT: begin
        if (kp.key_valid) begin
          w_idle_nxt = '0;
          if (w_is_digit) begin
            if (r_count < C_CNT_W'(MAX_DIGITS)) begin
              w_buf_nxt   = (r_buf << 4) | C_BUF_W'(kp.key_code[3:0]);
              w_count_nxt = r_count + 1'b1;
            end else begin
              w_reject_nxt = 1'b1;
            end
          end else if (kp.key_code == C_KEY_BS) begin
            // Backspace on an empty buffer is silently ignored
            if (r_count != '0) begin
              w_buf_nxt   = r_buf >> 4;
              w_count_nxt = r_count - 1'b1;
            end
          end else if (kp.key_code == C_KEY_ENTER) begin
            if (r_count >= C_CNT_W'(MIN_DIGITS)) begin
              w_state_nxt   = S_CONVERT;
              w_acc_nxt     = '0;
              w_idx_nxt     = r_count;
              w_ovf_acc_nxt = 1'b0;
            end else begin
              w_reject_nxt = 1'b1;
            end
          end else if (kp.key_code == C_KEY_ESC) begin
            w_cancel_nxt = 1'b1;
            w_buf_nxt    = '0;
            w_count_nxt  = '0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_reject_nxt = 1'b1;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (r_idle == C_TO_LAST) begin
            w_timeout_nxt = 1'b1;
            w_buf_nxt     = '0;
            w_count_nxt   = '0;
            w_idle_nxt    = '0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_idle_nxt = r_idle + 1'b1;
          end
        end
      end
      S_CONVERT: begin
        if (r_idx == '0) begin
          // Finalise; a key arriving in this cycle is dropped silently so done stays exclusive
          w_value_nxt = r_ovf_acc ? {VALUE_W{1'b1}} : r_acc[VALUE_W-1:0];
          w_ovf_nxt   = r_ovf_acc;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_acc_nxt     = w_acc_step;
          w_ovf_acc_nxt = r_ovf_acc | (|w_acc_step[C_ACC_W-1:VALUE_W]);
          w_idx_nxt     = r_idx - 1'b1;
          w_reject_nxt  = kp.key_valid;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; everything clears asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_buf     <= '0;
      r_count   <= '0;
      r_mask    <= 1'b0;
      r_idle    <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_ovf_acc <= 1'b0;
      r_value   <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_cancel  <= 1'b0;
      r_timeout <= 1'b0;
      r_reject  <= 1'b0;
      r_disp_en <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_buf     <= w_buf_nxt;
      r_count   <= w_count_nxt;
      r_mask    <= w_mask_nxt;
      r_idle    <= w_idle_nxt;
      r_acc     <= w_acc_nxt;
      r_idx     <= w_idx_nxt;
      r_ovf_acc <= w_ovf_acc_nxt;
      r_value   <= w_value_nxt;
      r_ovf     <= w_ovf_nxt;
      r_done    <= w_done_nxt;
      r_cancel  <= w_cancel_nxt;
      r_timeout <= w_timeout_nxt;
      r_reject  <= w_reject_nxt;
      r_disp_en <= 1'b1;
    end
  end

  // Display decode: empty positions show F, masked positions show the dash code
  for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_disp
    assign w_blank[gi]       = (C_CNT_W'(gi) >= r_count);
    assign w_disp[4*gi +: 4] = w_blank[gi] ? 4'hF : (r_mask ? 4'hA : r_buf[4*gi +: 4]);
  end

  // Display is forced low until the first clock after reset so all outputs read 0 in reset
  assign kp.disp_digits = r_disp_en ? w_disp  : '0;
  assign kp.disp_blank  = r_disp_en ? w_blank : '0;
  assign kp.busy        = (r_state != S_IDLE);
  assign kp.done        = r_done;
  assign kp.cancel      = r_cancel;
  assign kp.timeout     = r_timeout;
  assign kp.ovf         = r_ovf;
  assign kp.key_reject  = r_reject;
  assign kp.value       = r_value;
  assign kp.digit_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_entry_buffer
// Description : Self-checking bench for keypad_entry_buffer. Two instances
//               share one stimulus stream:
//                 - dut0: MIN 1, 16-bit result
//                 - dut1: MIN 4, 8-bit result
//               Both use MAX 4 and a timeout of 20. A list-based
//               behavioural model predicts every output each cycle.
//               Directed sequences pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_buffer;

  localparam int MAXD = 4;
  localparam int TO   = 20;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mask_en;
  logic       kv;
  logic [7:0] kc;

  int n_checks = 0;
  int n_errors = 0;
  int quiet    = 0;

  keypad_entry_buffer_if #(.MAX_DIGITS(MAXD), .VALUE_W(16)) if0 ();
  keypad_entry_buffer_if #(.MAX_DIGITS(MAXD), .VALUE_W(8))  if1 ();

  assign if0.start = start;  assign if0.mask_en = mask_en;
  assign if0.key_valid = kv; assign if0.key_code = kc;
  assign if1.start = start;  assign if1.mask_en = mask_en;
  assign if1.key_valid = kv; assign if1.key_code = kc;

  keypad_entry_buffer #(.MAX_DIGITS(MAXD), .MIN_DIGITS(1), .VALUE_W(16), .TIMEOUT_CYCLES(TO))
    dut0 (.clk(clk), .rst_n(rst_n), .kp(if0));
  keypad_entry_buffer #(.MAX_DIGITS(MAXD), .MIN_DIGITS(4), .VALUE_W(8), .TIMEOUT_CYCLES(TO))
    dut1 (.clk(clk), .rst_n(rst_n), .kp(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // m_st: 0 idle, 1 collecting, 2 converting. Digits are stored oldest first.
  int c_min[2] = '{1, 4};
  int c_vw[2]  = '{16, 8};
  int m_st[2], m_cnt[2], m_mask[2], m_idle[2], m_left[2];
  int m_val[2], m_ovf[2], m_done[2], m_cancel[2], m_to[2], m_rej[2];
  int m_buf[2][MAXD];
  int m_live;

  task automatic mreset(input int k);
    m_st[k] = 0; m_cnt[k] = 0; m_mask[k] = 0; m_idle[k] = 0; m_left[k] = 0;
    m_val[k] = 0; m_ovf[k] = 0; m_done[k] = 0; m_cancel[k] = 0; m_to[k] = 0; m_rej[k] = 0;
  endtask

  task automatic mstep(input int k);
    longint n;
    m_done[k] = 0; m_cancel[k] = 0; m_to[k] = 0; m_rej[k] = 0;
    if (m_st[k] == 0) begin
      if (start) begin
        m_st[k] = 1; m_cnt[k] = 0; m_val[k] = 0; m_ovf[k] = 0;
        m_mask[k] = int'(mask_en); m_idle[k] = 0;
      end
    end else if (m_st[k] == 1) begin
      if (kv) begin
        m_idle[k] = 0;
        if (kc >= 8'h30 && kc <= 8'h39) begin
          if (m_cnt[k] < MAXD) begin
            m_buf[k][m_cnt[k]] = int'(kc) - 48;
            m_cnt[k]++;
          end else m_rej[k] = 1;
        end else if (kc == 8'h08) begin
          if (m_cnt[k] > 0) m_cnt[k]--;
        end else if (kc == 8'h0D) begin
          if (m_cnt[k] >= c_min[k]) begin
            m_st[k] = 2; m_left[k] = m_cnt[k] + 1;
          end else m_rej[k] = 1;
        end else if (kc == 8'h1B) begin
          m_cancel[k] = 1; m_cnt[k] = 0; m_st[k] = 0;
        end else m_rej[k] = 1;
      end else begin
        m_idle[k]++;
        if (m_idle[k] == TO) begin
          m_to[k] = 1; m_cnt[k] = 0; m_st[k] = 0;
        end
      end
    end else begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        n = 0;
        for (int i = 0; i < m_cnt[k]; i++) n = n * 10 + m_buf[k][i];
        if (n >= (64'd1 << c_vw[k])) begin
          m_ovf[k] = 1; m_val[k] = int'((64'd1 << c_vw[k]) - 1);
        end else begin
          m_ovf[k] = 0; m_val[k] = int'(n);
        end
        m_done[k] = 1; m_st[k] = 0;
      end else if (kv) m_rej[k] = 1;
    end
  endtask

  // Advance the model on the same edges the design uses
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) mreset(k);
      m_live = 0;
    end else begin
      for (int k = 0; k < 2; k++) mstep(k);
      m_live = 1;
    end
  end

  function automatic logic [31:0] exp_dd(input int k);
    logic [31:0] r;
    logic [3:0]  nb;
    r = '0;
    if (m_live != 0) begin
      for (int i = 0; i < MAXD; i++) begin
        if (i >= m_cnt[k])       nb = 4'hF;
        else if (m_mask[k] != 0) nb = 4'hA;
        else                     nb = 4'(m_buf[k][m_cnt[k] - 1 - i]);
        r[4*i +: 4] = nb;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_bl(input int k);
    logic [31:0] r;
    r = '0;
    if (m_live != 0)
      for (int i = 0; i < MAXD; i++) r[i] = (i >= m_cnt[k]);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic b, input logic d, input logic c,
                          input logic t, input logic o, input logic r,
                          input logic [31:0] v, input logic [31:0] cnt,
                          input logic [31:0] dd, input logic [31:0] bl);
    check($sformatf("busy%0d", k),    32'(b), 32'(m_st[k] != 0));
    check($sformatf("done%0d", k),    32'(d), 32'(m_done[k]));
    check($sformatf("cancel%0d", k),  32'(c), 32'(m_cancel[k]));
    check($sformatf("timeout%0d", k), 32'(t), 32'(m_to[k]));
    check($sformatf("ovf%0d", k),     32'(o), 32'(m_ovf[k]));
    check($sformatf("reject%0d", k),  32'(r), 32'(m_rej[k]));
    check($sformatf("value%0d", k),   v,   32'(m_val[k]));
    check($sformatf("count%0d", k),   cnt, 32'(m_cnt[k]));
    check($sformatf("disp%0d", k),    dd,  exp_dd(k));
    check($sformatf("blank%0d", k),   bl,  exp_bl(k));
  endtask

  // Compare both instances against the model every cycle, away from the active edge
  always @(negedge clk) begin
    cmp_inst(0, if0.busy, if0.done, if0.cancel, if0.timeout, if0.ovf, if0.key_reject,
             32'(if0.value), 32'(if0.digit_count), 32'(if0.disp_digits), 32'(if0.disp_blank));
    cmp_inst(1, if1.busy, if1.done, if1.cancel, if1.timeout, if1.ovf, if1.key_reject,
             32'(if1.value), 32'(if1.digit_count), 32'(if1.disp_digits), 32'(if1.disp_blank));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] c);
    kv = 1'b1; kc = c;
    cyc();
    kv = 1'b0; kc = 8'h00;
  endtask

  task automatic do_start(input logic m);
    start = 1'b1; mask_en = m;
    cyc();
    start = 1'b0; mask_en = 1'b0;
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55)      return 8'h30 + 8'($urandom_range(0, 9));
    else if (r < 65) return 8'h08;
    else if (r < 77) return 8'h0D;
    else if (r < 81) return 8'h1B;
    else             return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    start = 1'b0; mask_en = 1'b0; kv = 1'b0; kc = 8'h00; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy0",  32'(if0.busy), 0);
    check("rst_blank0", 32'(if0.disp_blank), 0);
    check("rst_disp0",  32'(if0.disp_digits), 0);
    check("rst_value1", 32'(if1.value), 0);
    #2 rst_n = 1'b1;
    cyc();
    check("idle_blank0", 32'(if0.disp_blank), 32'h0000000F);

    // Basic entry 1,2,3,4 then ENTER
    do_start(1'b0);
    press("1"); press("2"); press("3"); press("4");
    check("disp_1234", 32'(if0.disp_digits), 32'h00001234);
    check("blank_1234", 32'(if0.disp_blank), 0);
    press(8'h0D);
    repeat (4) cyc();
    check("done_early0", 32'(if0.done), 0);
    cyc();
    check("done_n5_0",  32'(if0.done), 1);
    check("busy_fall0", 32'(if0.busy), 0);
    check("val_1234",   32'(if0.value), 32'h000004D2);
    check("ovf_1234",   32'(if0.ovf), 0);
    check("val1_1234",  32'(if1.value), 32'h000000FF);
    check("ovf1_1234",  32'(if1.ovf), 1);
    cyc();

    // Full buffer, fifth digit rejected, backspace then '1'
    do_start(1'b0);
    repeat (4) press("9");
    kv = 1'b1; kc = "9";
    cyc();
    kv = 1'b0; kc = 8'h00;
    check("rej_fifth", 32'(if0.key_reject), 1);
    press(8'h08); press("1"); press(8'h0D);
    repeat (5) cyc();
    check("val_9991", 32'(if0.value), 32'h00002707);
    check("done_9991", 32'(if0.done), 1);
    cyc();

    // Masking with ENTER below the minimum on dut1
    do_start(1'b1);
    press("5"); press("6");
    check("mask_digits1", 32'(if1.disp_digits[7:0]), 32'h000000AA);
    check("mask_blank1",  32'(if1.disp_blank), 32'h0000000C);
    press(8'h0D);
    check("enter_rej1", 32'(if1.key_reject), 1);
    check("enter_busy1", 32'(if1.busy), 1);
    press(8'h1B);
    check("esc_cancel1", 32'(if1.cancel), 1);
    repeat (3) cyc();

    // Overflow on the 8-bit instance: 0300
    do_start(1'b0);
    press("0"); press("3"); press("0"); press("0"); press(8'h0D);
    repeat (5) cyc();
    check("ovf1_300", 32'(if1.ovf), 1);
    check("val1_300", 32'(if1.value), 32'h000000FF);
    check("val0_300", 32'(if0.value), 32'h0000012C);
    cyc();

    // Cancel
    do_start(1'b0);
    press("7"); press(8'h1B);
    check("cancel0", 32'(if0.cancel), 1);
    check("cancel_busy0", 32'(if0.busy), 0);
    check("cancel_blank0", 32'(if0.disp_blank), 32'h0000000F);
    cyc();

    // Timeout exactly 20 cycles after start is accepted
    do_start(1'b0);
    repeat (TO - 1) cyc();
    check("to_early0", 32'(if0.timeout), 0);
    cyc();
    check("to_pulse0", 32'(if0.timeout), 1);
    check("to_busy0",  32'(if0.busy), 0);
    cyc();

    // Reset during conversion
    do_start(1'b0);
    press("1"); press("2"); press("3"); press(8'h0D);
    cyc();
    rst_n = 1'b0;
    #1;
    check("rstc_busy0",  32'(if0.busy), 0);
    check("rstc_value0", 32'(if0.value), 0);
    check("rstc_count0", 32'(if0.digit_count), 0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    check("rstc_nodone0", 32'(if0.done), 0);
    do_start(1'b0);
    press("8"); press(8'h0D);
    repeat (2) cyc();
    check("val_8", 32'(if0.value), 32'h00000008);
    check("done_8", 32'(if0.done), 1);
    cyc();

    // Randomized traffic
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end else begin
        if (quiet > 0) quiet--;
        else if ($urandom_range(0, 99) == 0) quiet = $urandom_range(15, 30);
        start   = ($urandom_range(0, 5) == 0);
        mask_en = 1'($urandom_range(0, 1));
        if (quiet == 0 && $urandom_range(0, 99) < 45) begin
          kv = 1'b1; kc = rand_key();
        end
        cyc();
        start = 1'b0; mask_en = 1'b0; kv = 1'b0; kc = 8'h00;
      end
    end

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
